// File: rtl/traffic_light.sv
// Timed Moore traffic-light controller cycling RED -> GREEN -> YELLOW -> RED.
// Lamp outputs are registered alongside the state so they change on the same edge as the state.
module traffic_light #(
    parameter int RED_CYCLES    = 10,
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    output logic red,
    output logic yellow,
    output logic green
);

    localparam int MAX_RG     = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
    localparam int MAX_CYCLES = (MAX_RG > YELLOW_CYCLES) ? MAX_RG : YELLOW_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

    if (RED_CYCLES < 1) begin : g_bad_red
        $fatal(1, "traffic_light: RED_CYCLES must be >= 1");
    end
    if (GREEN_CYCLES < 1) begin : g_bad_green
        $fatal(1, "traffic_light: GREEN_CYCLES must be >= 1");
    end
    if (YELLOW_CYCLES < 1) begin : g_bad_yellow
        $fatal(1, "traffic_light: YELLOW_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        RED    = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    // Lamps are loaded with the decode of the state being entered, so they always match state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RED;
            count  <= '0;
            red    <= 1'b1;
            yellow <= 1'b0;
            green  <= 1'b0;
        end else begin
            case (state)
                RED: begin
                    if (count == RED_LAST) begin
                        state  <= GREEN;
                        count  <= '0;
                        red    <= 1'b0;
                        yellow <= 1'b0;
                        green  <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                GREEN: begin
                    if (count == GREEN_LAST) begin
                        state  <= YELLOW;
                        count  <= '0;
                        red    <= 1'b0;
                        yellow <= 1'b1;
                        green  <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                YELLOW: begin
                    if (count == YELLOW_LAST) begin
                        state  <= RED;
                        count  <= '0;
                        red    <= 1'b1;
                        yellow <= 1'b0;
                        green  <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state  <= RED;
                    count  <= '0;
                    red    <= 1'b1;
                    yellow <= 1'b0;
                    green  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light.sv
// Directed self-checking bench for traffic_light: default timing plus a 1/1/1 instance.
module tb_traffic_light;

    logic clk;
    logic rst;
    logic rst1;
    logic red, yellow, green;
    logic red1, yellow1, green1;
    logic [2:0] lamps;
    logic [2:0] lamps1;

    int checks   = 0;
    int failures = 0;

    assign lamps  = {red, yellow, green};
    assign lamps1 = {red1, yellow1, green1};

    traffic_light dut (
        .clk    (clk),
        .rst    (rst),
        .red    (red),
        .yellow (yellow),
        .green  (green)
    );

    traffic_light #(
        .RED_CYCLES    (1),
        .GREEN_CYCLES  (1),
        .YELLOW_CYCLES (1)
    ) dut1 (
        .clk    (clk),
        .rst    (rst1),
        .red    (red1),
        .yellow (yellow1),
        .green  (green1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {red,yellow,green} after edge e (e >= 1) since release, default durations 10/8/3.
    function automatic logic [2:0] exp_lamps(input int e);
        if (e <= 9)       return 3'b100;
        else if (e <= 17) return 3'b001;
        else if (e <= 20) return 3'b010;
        else              return 3'b100;
    endfunction

    task automatic test_reset();
        rst  = 1'b1;
        rst1 = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (lamps !== 3'b100) begin
                failures++;
                $display("FAIL reset_edge%0d: lamps=%b expected=%b", i, lamps, 3'b100);
            end
            checks++;
            if (lamps1 !== 3'b100) begin
                failures++;
                $display("FAIL reset_dur1_edge%0d: lamps=%b expected=%b", i, lamps1, 3'b100);
            end
        end
    endtask

    task automatic test_cycle();
        rst = 1'b0;
        checks++;
        if (lamps !== 3'b100) begin
            failures++;
            $display("FAIL cycle_edge0: lamps=%b expected=%b", lamps, 3'b100);
        end
        for (int e = 1; e <= 30; e++) begin
            tick();
            checks++;
            if (lamps !== exp_lamps(e)) begin
                failures++;
                $display("FAIL cycle_edge%0d: lamps=%b expected=%b", e, lamps, exp_lamps(e));
            end
            checks++;
            if ($isunknown(lamps) || $countones(lamps) != 1) begin
                failures++;
                $display("FAIL onehot_edge%0d: lamps=%b expected exactly one lamp", e, lamps);
            end
        end
    endtask

    task automatic test_reset_mid_green();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) tick();
        checks++;
        if (lamps !== 3'b001) begin
            failures++;
            $display("FAIL midgreen_pre: lamps=%b expected=%b", lamps, 3'b001);
        end
        rst = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (lamps !== 3'b100) begin
                failures++;
                $display("FAIL midgreen_rst%0d: lamps=%b expected=%b", i, lamps, 3'b100);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++;
            if (lamps !== exp_lamps(e)) begin
                failures++;
                $display("FAIL midgreen_edge%0d: lamps=%b expected=%b", e, lamps, exp_lamps(e));
            end
        end
    endtask

    task automatic test_dur1();
        logic [2:0] exp;
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        checks++;
        if (lamps1 !== 3'b100) begin
            failures++;
            $display("FAIL dur1_edge0: lamps=%b expected=%b", lamps1, 3'b100);
        end
        for (int e = 1; e <= 9; e++) begin
            tick();
            case (e % 3)
                1:       exp = 3'b001;
                2:       exp = 3'b010;
                default: exp = 3'b100;
            endcase
            checks++;
            if (lamps1 !== exp) begin
                failures++;
                $display("FAIL dur1_edge%0d: lamps=%b expected=%b", e, lamps1, exp);
            end
        end
    endtask

    task automatic test_yellow_last();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 20; e++) tick();
        checks++;
        if (lamps !== 3'b010) begin
            failures++;
            $display("FAIL ylast_pre: lamps=%b expected=%b", lamps, 3'b010);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (lamps !== 3'b100) begin
            failures++;
            $display("FAIL ylast_rst: lamps=%b expected=%b", lamps, 3'b100);
        end
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (lamps !== exp_lamps(e)) begin
                failures++;
                $display("FAIL ylast_edge%0d: lamps=%b expected=%b", e, lamps, exp_lamps(e));
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        rst1 = 1'b1;
        @(negedge clk);
        test_reset();
        test_cycle();
        test_reset_mid_green();
        test_dur1();
        test_yellow_last();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
